// File: rtl/exe_mem_skid_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | exe_mem_skid_if                                                          |
// | Handshake and payload bundle between the EXE stage, skid stage and MEM.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface exe_mem_skid_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CTRL_W = 3
) ();
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] next_pc;
    logic [ADDR_W-1:0] reg_waddr;
    logic [CTRL_W-1:0] ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_result_out;
    logic [DATA_W-1:0] rdata2_out;
    logic [DATA_W-1:0] next_pc_out;
    logic [ADDR_W-1:0] reg_waddr_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [1:0]        occupancy;

    modport slave (
        input  flush, in_valid, alu_result, rdata2, next_pc, reg_waddr, ctrl, out_ready,
        output in_ready, out_valid, alu_result_out, rdata2_out, next_pc_out,
               reg_waddr_out, ctrl_out, occupancy
    );

    modport master (
        output flush, in_valid, alu_result, rdata2, next_pc, reg_waddr, ctrl, out_ready,
        input  in_ready, out_valid, alu_result_out, rdata2_out, next_pc_out,
               reg_waddr_out, ctrl_out, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/exe_mem_skid_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | exe_mem_skid_stage                                                       |
// | EXE->MEM pipeline register with a one-entry skid buffer; fully           |
// | registered outputs and an in_ready that never looks at out_ready.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module exe_mem_skid_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CTRL_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    exe_mem_skid_if.slave bus
);

    localparam int PAY_W = 3 * DATA_W + ADDR_W + CTRL_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PAY_W-1:0] main_q;
    logic [PAY_W-1:0] main_d;
    logic [PAY_W-1:0] skid_q;
    logic [PAY_W-1:0] skid_d;
    logic [PAY_W-1:0] in_payload;
    logic             in_ready;
    logic             out_valid;
    logic             in_fire;
    logic             out_fire;

    // Packed with ctrl in the low bits so a flush can clear it in place.
    assign in_payload = {bus.alu_result, bus.rdata2, bus.next_pc, bus.reg_waddr, bus.ctrl};

    assign in_ready  = (state_q != FULL) && !rst;
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = EMPTY;
            main_d  = {main_q[PAY_W-1:CTRL_W], {CTRL_W{1'b0}}};
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_payload;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d  = in_payload;
                    end else if (in_fire) begin
                        skid_d  = in_payload;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid;
    assign bus.occupancy      = state_q;
    assign bus.alu_result_out = main_q[PAY_W-1 -: DATA_W];
    assign bus.rdata2_out     = main_q[PAY_W-DATA_W-1 -: DATA_W];
    assign bus.next_pc_out    = main_q[DATA_W+ADDR_W+CTRL_W-1 -: DATA_W];
    assign bus.reg_waddr_out  = main_q[ADDR_W+CTRL_W-1 -: ADDR_W];
    assign bus.ctrl_out       = main_q[CTRL_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_exe_mem_skid_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_exe_mem_skid_stage                                                    |
// | Queue-model bench for the EXE->MEM skid stage.                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_exe_mem_skid_stage;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int CTRL_W = 3;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] rd2;
        logic [15:0] npc;
        logic [3:0]  wa;
        logic [2:0]  ct;
    } entry_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     checks = 0;
    int     failures = 0;
    entry_t model_q[$];
    bit     exp_ctrl_zero = 1'b1;
    bit     exp_all_zero = 1'b1;
    bit     m_in;
    bit     m_out;
    entry_t m_e;

    exe_mem_skid_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) bus ();

    exe_mem_skid_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an in-order FIFO of depth two with flush and reset clearing it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
            exp_ctrl_zero = 1'b1;
            exp_all_zero  = 1'b1;
        end else begin
            m_in  = bus.in_valid && (model_q.size() < 2);
            m_out = (model_q.size() > 0) && bus.out_ready;
            if (bus.flush) begin
                model_q.delete();
                exp_ctrl_zero = 1'b1;
            end else begin
                if (m_out) void'(model_q.pop_front());
                if (m_in) begin
                    m_e = '{alu: bus.alu_result, rd2: bus.rdata2, npc: bus.next_pc,
                            wa: bus.reg_waddr, ct: bus.ctrl};
                    model_q.push_back(m_e);
                    exp_ctrl_zero = 1'b0;
                    exp_all_zero  = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(bus.in_ready), 32'(!rst && (model_q.size() < 2)));
        chk("out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
        chk("occupancy", 32'(bus.occupancy), 32'(model_q.size()));
        if (model_q.size() != 0) begin
            chk("alu_out", 32'(bus.alu_result_out), 32'(model_q[0].alu));
            chk("rdata2_out", 32'(bus.rdata2_out), 32'(model_q[0].rd2));
            chk("next_pc_out", 32'(bus.next_pc_out), 32'(model_q[0].npc));
            chk("waddr_out", 32'(bus.reg_waddr_out), 32'(model_q[0].wa));
            chk("ctrl_out", 32'(bus.ctrl_out), 32'(model_q[0].ct));
        end else begin
            if (exp_ctrl_zero) chk("ctrl_idle", 32'(bus.ctrl_out), 32'd0);
            if (exp_all_zero) begin
                chk("alu_rst", 32'(bus.alu_result_out), 32'd0);
                chk("rdata2_rst", 32'(bus.rdata2_out), 32'd0);
                chk("next_pc_rst", 32'(bus.next_pc_out), 32'd0);
                chk("waddr_rst", 32'(bus.reg_waddr_out), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic v, input logic [15:0] alu, input logic [3:0] wa,
                          input logic [2:0] ct);
        bus.in_valid   = v;
        bus.alu_result = alu;
        bus.rdata2     = ~alu;
        bus.next_pc    = alu + 16'h0004;
        bus.reg_waddr  = wa;
        bus.ctrl       = ct;
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, 16'h0000, 4'h0, 3'b000);
        repeat (3) step();

        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_alu", 32'(bus.alu_result_out), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Single transfer
        set_in(1'b1, 16'h1234, 4'h5, 3'b010);
        bus.out_ready = 1'b1;
        step();
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_alu", 32'(bus.alu_result_out), 32'h1234);
        chk("t1_waddr", 32'(bus.reg_waddr_out), 32'h5);
        chk("t1_ctrl", 32'(bus.ctrl_out), 32'h2);
        chk("t1_occ", 32'(bus.occupancy), 32'd1);
        set_in(1'b0, 16'h0000, 4'h0, 3'b000);
        step();
        chk("t1_drain", 32'(bus.occupancy), 32'd0);

        // Backpressure fills the skid
        bus.out_ready = 1'b0;
        set_in(1'b1, 16'h0001, 4'h1, 3'b010);
        step();
        set_in(1'b1, 16'h0002, 4'h2, 3'b011);
        step();
        set_in(1'b0, 16'h0000, 4'h0, 3'b000);
        chk("bp_occ", 32'(bus.occupancy), 32'd2);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_head", 32'(bus.alu_result_out), 32'h0001);
        step();
        chk("bp_stable", 32'(bus.alu_result_out), 32'h0001);
        bus.out_ready = 1'b1;
        step();
        chk("bp_pop_b", 32'(bus.alu_result_out), 32'h0002);
        chk("bp_pop_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_pop_occ", 32'(bus.occupancy), 32'd1);
        step();
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // Streaming at full rate
        for (int i = 0; i < 256; i++) begin
            set_in(1'b1, 16'(i), 4'(i), 3'(i));
            step();
            chk("stream_alu", 32'(bus.alu_result_out), 32'(i));
            chk("stream_occ", 32'(bus.occupancy), 32'd1);
        end
        set_in(1'b0, 16'h0000, 4'h0, 3'b000);
        step();

        // Flush while full
        bus.out_ready = 1'b0;
        set_in(1'b1, 16'h0AAA, 4'hA, 3'b111);
        step();
        set_in(1'b1, 16'h0BBB, 4'hB, 3'b111);
        step();
        chk("fl_full", 32'(bus.occupancy), 32'd2);
        bus.flush = 1'b1;
        set_in(1'b1, 16'hDEAD, 4'hD, 3'b111);
        step();
        bus.flush = 1'b0;
        set_in(1'b0, 16'h0000, 4'h0, 3'b000);
        chk("fl_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_occ", 32'(bus.occupancy), 32'd0);
        chk("fl_ctrl", 32'(bus.ctrl_out), 32'd0);
        chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
        chk("fl_alu_hold", 32'(bus.alu_result_out), 32'h0AAA);
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("fl_gone", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset while full
        bus.out_ready = 1'b0;
        set_in(1'b1, 16'h5555, 4'h3, 3'b101);
        step();
        set_in(1'b1, 16'h6666, 4'h4, 3'b110);
        step();
        set_in(1'b0, 16'h0000, 4'h0, 3'b000);
        chk("ar_full", 32'(bus.occupancy), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_occ", 32'(bus.occupancy), 32'd0);
        chk("ar_alu", 32'(bus.alu_result_out), 32'd0);
        chk("ar_ctrl", 32'(bus.ctrl_out), 32'd0);
        chk("ar_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("ar_in_ready_hold", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("ar_release", 32'(bus.in_ready), 32'd1);
        set_in(1'b1, 16'h7777, 4'h7, 3'b001);
        step();
        chk("ar_first_cap", 32'(bus.alu_result_out), 32'h7777);
        set_in(1'b0, 16'h0000, 4'h0, 3'b000);
        bus.out_ready = 1'b1;
        step();

        // Random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            set_in(1'($urandom_range(0, 9) < 7), 16'($urandom), 4'($urandom), 3'($urandom));
            bus.rdata2    = 16'($urandom);
            bus.next_pc   = 16'($urandom);
            bus.out_ready = 1'($urandom_range(0, 9) < 6);
            bus.flush     = 1'($urandom_range(0, 31) == 0);
            step();
        end
        bus.flush = 1'b0;
        set_in(1'b0, 16'h0000, 4'h0, 3'b000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
